spi_ram_master_ctrl: RTL and testbench
======================================

Name: spi_ram_master_ctrl

Overview:
Host-side SPI master that sequences byte read/write transactions to the SPI-slave/single-port-RAM block. It turns a simple valid/ready request into the slave's 11-bit command frames: a selector bit, a 2-bit command and 8 data bits. It drives SS_n and MOSI, samples MISO, and returns read data on a one-cycle response strobe. It sits between a system bus bridge and the SPI slave, sharing clk with it.

Parameters:
GAP, 2, number of cycles SS_n is held high between frames and after the final frame (min 1).
MISO_LAT, 2, posedges from the last-MOSI-bit sample edge to the rdata[7] sample edge (min 1).
SKIP_ADDR, 1, when 1, omit the write-address frame if req_addr equals the cached last-written address.

Ports:
clk  input  1  system clock; also the SPI bit clock of the slave.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  1  host request present.
req_ready  output  1  high only in IDLE; request accepted on a posedge with req_valid&req_ready.
req_write  input  1  1 = write, 0 = read.
req_addr  input  8  RAM address.
req_wdata  input  8  write data; ignored for reads.
rsp_valid  output  1  one-cycle completion pulse for both reads and writes.
rsp_rdata  output  8  read data; valid with rsp_valid on reads, holds its last value otherwise.
SS_n  output  1  slave select, active low.
MOSI  output  1  serial data to slave.
MISO  input  1  serial data from slave.

Behaviour:
- Reset (async): state IDLE; SS_n=1, MOSI=0, rsp_valid=0, rsp_rdata=0, req_ready=1, address cache invalid. Reset mid-frame aborts immediately. No response is issued for the aborted request.
- All outputs are registered on posedge clk. Request fields are latched at acceptance.
- Frame format, MSB first: sel, c1, c0, d7..d0, with sel = c1.
  - Command 00 = write address; 01 = write data; 10 = read address; 11 = read data.
  - In a read-data frame, d7..d0 are driven as 0.
- Frame timing: SS_n goes low and MOSI=0 for 1 setup cycle. Then 11 bits follow, one per cycle, so SS_n is low for 12 cycles per MOSI-only frame.
- States: IDLE -> LOAD (select frame) -> SETUP -> SHIFT (bit_cnt 10..0) -> [WAIT_MISO -> CAPTURE] -> GAP -> next frame or IDLE.
- Write sequence:
  - Address frame (00), GAP, data frame (01), GAP, then IDLE.
  - rsp_valid pulses on the first GAP cycle after the data frame.
  - Address cache is updated when the address frame completes.
- Write address skip: when SKIP_ADDR=1, the cache is valid and req_addr matches, only the data frame is sent.
- Read sequence:
  - Address frame (10), GAP, read-data frame (11).
  - After the last MOSI bit, SS_n stays low and MOSI=0 through WAIT_MISO (MISO_LAT-1 cycles).
  - CAPTURE then samples 8 MISO bits on consecutive posedges into rdata[7..0].
  - SS_n goes high and rsp_valid=1 with rsp_rdata in the cycle after the 8th sample. GAP follows, then IDLE.
  - Read address is never cached.
- Timing with GAP=2, MISO_LAT=2:
  - Write without skip: 28 cycles from acceptance+1 until req_ready=1.
  - Write with skip: 14 cycles.
  - Read: 12+2+12+1+8+2 = 37 cycles.
- Boundary conditions:
  - req_valid held high in IDLE starts the next request the cycle after req_ready is seen.
  - req_valid while busy is ignored; req_ready=0.
  - Addresses 0x00 and 0xFF are legal.
  - The cache compare covers the full 8 bits.

Test Plan:
- Write addr 0x3C, data 0xA5 after reset -> MOSI bits 0,0,0,00111100; SS_n high 2 cycles; then 0,0,1,10100101; rsp_valid after 24 low + 2 high cycles; slave RAM[0x3C]=0xA5.
- Read addr 0x3C with the slave model -> MOSI 1,1,0,00111100 then 1,1,1,00000000; 8 MISO bits captured; rsp_rdata=0xA5 with a single-cycle rsp_valid.
- Second write to 0x3C with data 0x5A (SKIP_ADDR=1) -> only frame 0,0,1,01011010 is sent; readback returns 0x5A; a write to 0x3D sends both frames.
- Back-to-back requests with req_valid held -> SS_n high exactly GAP cycles between every frame; no request is dropped or duplicated.
- rst_n pulled low mid-SHIFT of a write-data frame -> SS_n=1 and MOSI=0 immediately, no rsp_valid. The next write to the same address sends the address frame again (cache invalidated).
- Boundary addresses 0x00 and 0xFF with data 0xFF and 0x00 -> correct frames are sent and the readback values match.

Source files
------------

// File: rtl/spi_ram_master_ctrl.sv
// spi_ram_master_ctrl: host-side SPI master for the SPI-slave / single-port RAM.
// Turns a valid/ready byte request into 11-bit frames {sel, c1, c0, d7..d0}.
// Ports:
//   clk, rst_n             shared system / SPI bit clock, async active-low reset
//   req_valid/req_ready    request handshake (ready only while idle)
//   req_write/addr/wdata   request fields, latched at acceptance
//   rsp_valid/rsp_rdata    one-cycle completion pulse, read data held until next read
//   SS_n/MOSI/MISO         serial interface to the slave
module spi_ram_master_ctrl #(
  parameter int unsigned GAP       = 2,
  parameter int unsigned MISO_LAT  = 2,
  parameter int unsigned SKIP_ADDR = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  localparam int unsigned FRAME_W = 11;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned BCNT_W  = 4;

  localparam logic [1:0] CMD_WADDR = 2'b00;
  localparam logic [1:0] CMD_WDATA = 2'b01;
  localparam logic [1:0] CMD_RADDR = 2'b10;
  localparam logic [1:0] CMD_RDATA = 2'b11;

  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP - 1);
  // Only meaningful when MISO_LAT > 1; WAIT_MISO is skipped otherwise.
  localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(MISO_LAT - 2);
  localparam logic [CNT_W-1:0]  CAP_LAST  = CNT_W'(7);
  localparam logic [BCNT_W-1:0] LAST_BIT  = BCNT_W'(FRAME_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETUP,
    S_SHIFT,
    S_WAIT,
    S_CAPTURE,
    S_GAP
  } state_t;

  state_t               state_q;
  logic [1:0]           cmd_q;
  logic [7:0]           addr_q;
  logic [7:0]           wdata_q;
  logic [FRAME_W-1:0]   frame_q;
  logic [BCNT_W-1:0]    bit_cnt_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [7:0]           rdata_sh_q;
  logic                 last_q;
  logic [7:0]           cache_addr_q;
  logic                 cache_vld_q;
  logic                 req_ready_q;
  logic                 rsp_valid_q;
  logic [7:0]           rsp_rdata_q;
  logic                 ss_n_q;
  logic                 mosi_q;

  logic                 skip_hit_c;

  // Builds a frame; sel always mirrors c1, read-data frames carry zeros.
  function automatic logic [FRAME_W-1:0] frame_of(input logic [1:0] cmd,
                                                  input logic [7:0] addr,
                                                  input logic [7:0] wdata);
    logic [7:0] d;
    case (cmd)
      CMD_WDATA: d = wdata;
      CMD_RDATA: d = 8'h00;
      default:   d = addr;
    endcase
    return {cmd[1], cmd, d};
  endfunction

  // Write address frame can be dropped when the slave already holds this address.
  assign skip_hit_c = (SKIP_ADDR != 0) && cache_vld_q && (cache_addr_q == req_addr);

  // Sequencer: state, frame shifter, capture and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cmd_q        <= CMD_WADDR;
      addr_q       <= '0;
      wdata_q      <= '0;
      frame_q      <= '0;
      bit_cnt_q    <= '0;
      cnt_q        <= '0;
      rdata_sh_q   <= '0;
      last_q       <= 1'b0;
      cache_addr_q <= '0;
      cache_vld_q  <= 1'b0;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      ss_n_q       <= 1'b1;
      mosi_q       <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready_q) begin
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            last_q      <= 1'b0;
            req_ready_q <= 1'b0;
            state_q     <= S_LOAD;
            if (!req_write) begin
              cmd_q <= CMD_RADDR;
            end else if (skip_hit_c) begin
              cmd_q <= CMD_WDATA;
            end else begin
              cmd_q <= CMD_WADDR;
            end
          end
        end

        S_LOAD: begin
          frame_q <= frame_of(cmd_q, addr_q, wdata_q);
          ss_n_q  <= 1'b0;
          mosi_q  <= 1'b0;
          state_q <= S_SETUP;
        end

        S_SETUP: begin
          mosi_q    <= frame_q[FRAME_W-1];
          frame_q   <= {frame_q[FRAME_W-2:0], 1'b0};
          bit_cnt_q <= LAST_BIT;
          state_q   <= S_SHIFT;
        end

        S_SHIFT: begin
          if (bit_cnt_q != '0) begin
            mosi_q    <= frame_q[FRAME_W-1];
            frame_q   <= {frame_q[FRAME_W-2:0], 1'b0};
            bit_cnt_q <= bit_cnt_q - BCNT_W'(1);
          end else begin
            // Last bit has been on MOSI for a full cycle; frame is done.
            mosi_q <= 1'b0;
            cnt_q  <= '0;
            case (cmd_q)
              CMD_WADDR: begin
                cache_addr_q <= addr_q;
                cache_vld_q  <= 1'b1;
                cmd_q        <= CMD_WDATA;
                ss_n_q       <= 1'b1;
                state_q      <= S_GAP;
              end
              CMD_WDATA: begin
                rsp_valid_q <= 1'b1;
                last_q      <= 1'b1;
                ss_n_q      <= 1'b1;
                state_q     <= S_GAP;
              end
              CMD_RADDR: begin
                cmd_q   <= CMD_RDATA;
                ss_n_q  <= 1'b1;
                state_q <= S_GAP;
              end
              default: begin
                // Read data: keep SS_n low while the slave turns its data around.
                state_q <= (MISO_LAT > 1) ? S_WAIT : S_CAPTURE;
              end
            endcase
          end
        end

        S_WAIT: begin
          if (cnt_q == WAIT_LAST) begin
            cnt_q   <= '0;
            state_q <= S_CAPTURE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_CAPTURE: begin
          rdata_sh_q <= {rdata_sh_q[6:0], MISO};
          if (cnt_q == CAP_LAST) begin
            rsp_rdata_q <= {rdata_sh_q[6:0], MISO};
            rsp_valid_q <= 1'b1;
            last_q      <= 1'b1;
            ss_n_q      <= 1'b1;
            cnt_q       <= '0;
            state_q     <= S_GAP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q <= '0;
            if (last_q) begin
              req_ready_q <= 1'b1;
              state_q     <= S_IDLE;
            end else begin
              // Next frame's setup cycle starts right after the gap.
              frame_q <= frame_of(cmd_q, addr_q, wdata_q);
              ss_n_q  <= 1'b0;
              mosi_q  <= 1'b0;
              state_q <= S_SETUP;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
          ss_n_q      <= 1'b1;
          mosi_q      <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign SS_n      = ss_n_q;
  assign MOSI      = mosi_q;

endmodule

// File: tb/tb_spi_ram_master_ctrl.sv
// Directed bench for spi_ram_master_ctrl with a behavioural SPI RAM slave,
// a frame scoreboard and a response scoreboard.
module tb_spi_ram_master_ctrl;

  localparam int unsigned GAP       = 2;
  localparam int unsigned MISO_LAT  = 2;
  localparam int unsigned SKIP_ADDR = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       SS_n;
  logic       MOSI;
  logic       MISO = 1'b0;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int acc_cyc  = 0;
  int prev_acc = 0;

  logic [10:0] exp_frames[$];
  logic [7:0]  exp_rsp[$];

  // Bench-side reference model
  logic [7:0] mdl_mem [256];
  logic [7:0] mdl_cache = 8'h00;
  logic       mdl_vld   = 1'b0;
  logic [7:0] mdl_last  = 8'h00;

  // Slave model state
  int          s_cnt = 0;
  logic [10:0] s_sh  = '0;
  logic [1:0]  s_cmd = 2'b00;
  logic [7:0]  s_wa  = 8'h00;
  logic [7:0]  s_ra  = 8'h00;
  logic [7:0]  s_out = 8'h00;
  logic [7:0]  s_ram [256];

  // SS_n shape monitor state
  int   hi_n = 0;
  int   lo_n = 0;
  logic seen_lo = 1'b0;
  logic rdy_in_hi = 1'b0;
  logic rsp_prev = 1'b0;

  spi_ram_master_ctrl #(
    .GAP       (GAP),
    .MISO_LAT  (MISO_LAT),
    .SKIP_ADDR (SKIP_ADDR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .MISO      (MISO)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obsv, input logic [31:0] expv);
    tests++;
    assert (obsv === expv) else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obsv, expv);
    end
  endtask

  // SPI RAM slave: setup edge, 11 bit edges, then MISO turnaround for read data.
  task automatic slave_step();
    int j;
    if (SS_n !== 1'b0) begin
      s_cnt = 0;
      s_cmd = 2'b00;
      MISO <= 1'b0;
    end else begin
      if (s_cnt == 0) chk("mosi_setup", 32'(MOSI), 0);
      else if (s_cnt <= 11) s_sh = {s_sh[9:0], MOSI};
      else chk("mosi_tail", 32'(MOSI), 0);
      if (s_cnt == 11) begin
        chk("frame_pending", 32'(exp_frames.size() != 0), 1);
        if (exp_frames.size() != 0) chk("frame", 32'(s_sh), 32'(exp_frames.pop_front()));
        s_cmd = s_sh[9:8];
        case (s_cmd)
          2'b00:   s_wa = s_sh[7:0];
          2'b01:   s_ram[s_wa] = s_sh[7:0];
          2'b10:   s_ra = s_sh[7:0];
          default: s_out = s_ram[s_ra];
        endcase
      end
      j = s_cnt - 10 - int'(MISO_LAT);
      if (s_cnt >= 11 && s_cmd == 2'b11 && j >= 0 && j < 8) MISO <= s_out[7 - j];
      else MISO <= 1'b0;
      s_cnt++;
    end
  endtask

  always @(posedge clk) slave_step();

  // SS_n low-period length and high-gap length checks.
  task automatic ss_step();
    if (!rst_n) begin
      hi_n = 0; lo_n = 0; seen_lo = 1'b0; rdy_in_hi = 1'b0;
    end else if (SS_n) begin
      if (lo_n != 0) chk("ss_low_len", 32'(lo_n == 12 || lo_n == 12 + int'(MISO_LAT) - 1 + 8), 1);
      lo_n = 0;
      hi_n++;
      if (req_ready) rdy_in_hi = 1'b1;
    end else begin
      if (seen_lo && hi_n != 0) begin
        if (rdy_in_hi) chk("gap_between_req", 32'(hi_n >= int'(GAP)), 1);
        else chk("gap_in_req", 32'(hi_n), 32'(GAP));
      end
      hi_n = 0; rdy_in_hi = 1'b0; seen_lo = 1'b1;
      lo_n++;
    end
  endtask

  // Response scoreboard: one pending entry per accepted request.
  task automatic rsp_step();
    if (!rst_n) begin
      rsp_prev = 1'b0;
    end else begin
      if (rsp_valid) begin
        chk("rsp_pending", 32'(exp_rsp.size() != 0), 1);
        chk("rsp_single", 32'(rsp_prev), 0);
        if (exp_rsp.size() != 0) chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rsp.pop_front()));
      end
      rsp_prev = rsp_valid;
    end
  endtask

  always @(negedge clk) begin
    ss_step();
    rsp_step();
  end

  // Presents a request and returns just after the accepting edge; req_valid stays high.
  task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    while (!req_ready && n < 500) begin @(negedge clk); n++; end
    chk("accept_timeout", 32'(req_ready), 1);
    if (w) begin
      if (!(SKIP_ADDR != 0 && mdl_vld && mdl_cache == a)) exp_frames.push_back({3'b000, a});
      exp_frames.push_back({3'b001, d});
      mdl_vld = 1'b1; mdl_cache = a; mdl_mem[a] = d;
      exp_rsp.push_back(mdl_last);
    end else begin
      exp_frames.push_back({3'b110, a});
      exp_frames.push_back({3'b111, 8'h00});
      mdl_last = mdl_mem[a];
      exp_rsp.push_back(mdl_last);
    end
    @(posedge clk);
    #1;
    prev_acc = acc_cyc;
    acc_cyc  = cyc;
  endtask

  task automatic wait_idle(output int lat);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 500) begin @(negedge clk); n++; end
    chk("idle_timeout", 32'(req_ready), 1);
    lat = cyc - acc_cyc - 1;
  endtask

  task automatic req(input logic w, input logic [7:0] a, input logic [7:0] d, output int lat);
    issue(w, a, d);
    req_valid = 1'b0;
    wait_idle(lat);
  endtask

  initial begin
    int lat;
    rst_n = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ss_n", 32'(SS_n), 1);
    chk("rst_mosi", 32'(MOSI), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
    chk("rst_req_ready", 32'(req_ready), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // First write, with a competing request held while busy
    issue(1'b1, 8'h3C, 8'hA5);
    req_write = 1'b0; req_addr = 8'h99;
    repeat (8) begin @(negedge clk); chk("busy_ready", 32'(req_ready), 0); end
    req_valid = 1'b0;
    wait_idle(lat);
    chk("wr_lat", 32'(lat), 28);
    chk("slave_ram_3c", 32'(s_ram[8'h3C]), 32'h A5);

    req(1'b0, 8'h3C, 8'h00, lat);
    chk("rd_lat", 32'(lat), 37);

    // Cached address: data frame only
    req(1'b1, 8'h3C, 8'h5A, lat);
    chk("wr_skip_lat", 32'(lat), 14);
    req(1'b0, 8'h3C, 8'h00, lat);
    req(1'b1, 8'h3D, 8'hC3, lat);
    chk("wr_new_addr_lat", 32'(lat), 28);
    chk("slave_ram_3d", 32'(s_ram[8'h3D]), 32'h C3);

    // Back-to-back with req_valid held
    issue(1'b1, 8'h10, 8'h01);
    issue(1'b1, 8'h10, 8'h02);
    chk("b2b_acc_wr", 32'(acc_cyc - prev_acc), 30);
    issue(1'b0, 8'h10, 8'h00);
    chk("b2b_acc_wr_skip", 32'(acc_cyc - prev_acc), 16);
    issue(1'b1, 8'h20, 8'h03);
    chk("b2b_acc_rd", 32'(acc_cyc - prev_acc), 39);
    issue(1'b0, 8'h20, 8'h00);
    chk("b2b_acc_wr2", 32'(acc_cyc - prev_acc), 30);
    req_valid = 1'b0;
    wait_idle(lat);

    // Boundary addresses and data
    req(1'b1, 8'h00, 8'hFF, lat);
    req(1'b1, 8'hFF, 8'h00, lat);
    req(1'b0, 8'h00, 8'h00, lat);
    req(1'b0, 8'hFF, 8'h00, lat);
    chk("slave_ram_00", 32'(s_ram[8'h00]), 32'h FF);
    chk("slave_ram_ff", 32'(s_ram[8'hFF]), 32'h 00);

    // Reset during the data frame of a cached write
    req(1'b1, 8'h77, 8'h11, lat);
    issue(1'b1, 8'h77, 8'h22);
    req_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_ss_n", 32'(SS_n), 1);
    chk("abort_mosi", 32'(MOSI), 0);
    chk("abort_rsp_valid", 32'(rsp_valid), 0);
    chk("abort_req_ready", 32'(req_ready), 1);
    chk("abort_rsp_rdata", 32'(rsp_rdata), 0);
    exp_frames.delete();
    exp_rsp.delete();
    mdl_vld = 1'b0;
    mdl_mem[8'h77] = 8'h11;
    mdl_last = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("abort_slave_ram", 32'(s_ram[8'h77]), 32'h 11);
    req(1'b1, 8'h77, 8'h33, lat);
    chk("wr_after_reset_lat", 32'(lat), 28);
    req(1'b0, 8'h77, 8'h00, lat);

    repeat (5) @(negedge clk);
    chk("frames_left", 32'(exp_frames.size()), 0);
    chk("rsp_left", 32'(exp_rsp.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
